// File: rtl/debug_controller.sv
// UART-side loader and debug unit for the MIPS pipeline: program load,
// run/single-step gating and PC/register/data-memory dump.
module debug_controller #(
   parameter int                 NB_DATA     = 32,
   parameter int                 NB_REG      = 5,
   parameter int                 NB_ADDR     = 7,
   parameter int                 N_REGISTER  = 32,
   parameter int                 N_MEM_WORDS = 32,
   parameter int                 INST_DEPTH  = 256,
   parameter logic [NB_DATA-1:0] HALT_INSTR  = 32'hFFFF_FFFF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [7:0]         rx_data_i,
   input  logic               rx_done_i,
   input  logic               tx_done_i,
   output logic               tx_start_o,
   output logic [7:0]         tx_data_o,
   input  logic               halt_signal_i,
   input  logic [NB_DATA-1:0] data_pc_debug_i,
   input  logic [NB_DATA-1:0] data_registers_debug_i,
   input  logic [NB_DATA-1:0] data_mem_debug_i,
   output logic               select_debug_or_wireA_o,
   output logic [NB_REG-1:0]  addr_reg_debug_o,
   output logic               select_debug_or_alu_result_o,
   output logic [NB_ADDR-1:0] addr_mem_debug_o,
   output logic [NB_DATA-1:0] data_inst_to_write_o,
   output logic               ready_instr_to_write_o,
   output logic [NB_DATA-1:0] o_dir_mem_write_o,
   output logic               en_pipeline_o,
   output logic               en_read_inst_o,
   output logic [3:0]         state_o
);

   localparam int N_WORDS = 1 + N_REGISTER + N_MEM_WORDS;
   localparam int NB_IDX  = $clog2(N_WORDS + 1);

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_NEXT = 8'h4E;
   localparam logic [7:0] CMD_END  = 8'h45;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_WRITE, S_READY, S_RUN, S_STEP_WAIT,
      S_STEP_EXEC, S_DUMP_SET, S_DUMP_WAIT, S_DUMP_SEND,
      S_DUMP_HOLD, S_DONE
   } state_t;

   state_t             state, next;
   logic [NB_DATA-1:0] word, wr_addr, shift, rd_data;
   logic [1:0]         byte_cnt, byte_idx;
   logic [NB_IDX-1:0]  dump_idx, reg_off, mem_off;
   logic               ret_done, in_dump, is_reg, is_mem;
   logic               last_word, last_inst;

   assign in_dump   = state inside {S_DUMP_SET, S_DUMP_WAIT,
                                    S_DUMP_SEND, S_DUMP_HOLD};
   assign is_reg    = dump_idx != '0 &&
                      dump_idx <= NB_IDX'(N_REGISTER);
   assign is_mem    = dump_idx > NB_IDX'(N_REGISTER);
   assign reg_off   = dump_idx - NB_IDX'(1);
   assign mem_off   = dump_idx - NB_IDX'(1 + N_REGISTER);
   assign last_word = dump_idx == NB_IDX'(N_WORDS - 1);
   assign last_inst = (wr_addr >> 2) == NB_DATA'(INST_DEPTH - 1);

   always_comb begin
      rd_data = data_pc_debug_i;
      if (is_reg)      rd_data = data_registers_debug_i;
      else if (is_mem) rd_data = data_mem_debug_i;
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= next;
   end

   always_comb begin
      next                         = state;
      tx_start_o                   = 1'b0;
      tx_data_o                    = '0;
      select_debug_or_wireA_o      = in_dump;
      select_debug_or_alu_result_o = in_dump;
      addr_reg_debug_o             = '0;
      addr_mem_debug_o             = '0;
      data_inst_to_write_o         = '0;
      ready_instr_to_write_o       = 1'b0;
      o_dir_mem_write_o            = wr_addr;
      en_pipeline_o                = 1'b0;
      en_read_inst_o               = 1'b1;
      state_o                      = state;
      if (in_dump && is_reg) addr_reg_debug_o = NB_REG'(reg_off);
      if (in_dump && is_mem) addr_mem_debug_o = NB_ADDR'(mem_off);
      unique case (state)
         S_IDLE: begin
            en_read_inst_o = 1'b0;
            if (rx_done_i && rx_data_i == CMD_LOAD) next = S_LOAD;
         end
         S_LOAD: begin
            en_read_inst_o = 1'b0;
            if (rx_done_i && byte_cnt == 2'd3) next = S_WRITE;
         end
         S_WRITE: begin
            en_read_inst_o         = 1'b0;
            ready_instr_to_write_o = 1'b1;
            data_inst_to_write_o   = word;
            if (word == HALT_INSTR || last_inst) next = S_READY;
            else                                 next = S_LOAD;
         end
         S_READY: begin
            if (rx_done_i && rx_data_i == CMD_CONT)      next = S_RUN;
            else if (rx_done_i && rx_data_i == CMD_STEP) next = S_STEP_WAIT;
         end
         S_RUN: begin
            en_pipeline_o = 1'b1;
            if (halt_signal_i) next = S_DUMP_SET;
         end
         S_STEP_WAIT: begin
            if (rx_done_i && rx_data_i == CMD_NEXT)     next = S_STEP_EXEC;
            else if (rx_done_i && rx_data_i == CMD_END) next = S_RUN;
         end
         S_STEP_EXEC: begin
            en_pipeline_o = 1'b1;
            next          = S_DUMP_SET;
         end
         S_DUMP_SET:  next = S_DUMP_WAIT;
         S_DUMP_WAIT: next = S_DUMP_SEND;
         S_DUMP_SEND: begin
            tx_start_o = 1'b1;
            tx_data_o  = shift[NB_DATA-1 -: 8];
            next       = S_DUMP_HOLD;
         end
         S_DUMP_HOLD: begin
            tx_data_o = shift[NB_DATA-1 -: 8];
            if (tx_done_i) begin
               if (byte_idx != 2'd3)             next = S_DUMP_SEND;
               else if (!last_word)              next = S_DUMP_SET;
               else if (ret_done || halt_signal_i) next = S_DONE;
               else                              next = S_STEP_WAIT;
            end
         end
         S_DONE: en_read_inst_o = 1'b0;
         default: begin
            en_read_inst_o = 1'b0;
            next           = S_IDLE;
         end
      endcase
   end

   // A halt seen during or after a step makes the dump terminal.
   always_ff @(posedge clock) begin
      if (reset) begin
         word     <= '0;
         wr_addr  <= '0;
         byte_cnt <= '0;
         shift    <= '0;
         byte_idx <= '0;
         dump_idx <= '0;
         ret_done <= 1'b0;
      end else begin
         if (state == S_LOAD && rx_done_i) begin
            word     <= {word[NB_DATA-9:0], rx_data_i};
            byte_cnt <= byte_cnt + 2'd1;
         end
         if (state == S_WRITE) wr_addr <= wr_addr + NB_DATA'(4);
         if (state == S_RUN ||
             (halt_signal_i && (state == S_STEP_EXEC || in_dump)))
            ret_done <= 1'b1;
         if (!in_dump) begin
            byte_idx <= '0;
            dump_idx <= '0;
         end
         if (state == S_DUMP_WAIT) shift <= rd_data;
         if (state == S_DUMP_HOLD && tx_done_i) begin
            shift    <= shift << 8;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) dump_idx <= dump_idx + NB_IDX'(1);
         end
      end
   end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: load, run, step and dump
// checked against a byte scoreboard and a write-strobe queue.
module tb_debug_controller;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_READY     = 4'd3;
   localparam logic [3:0] S_RUN       = 4'd4;
   localparam logic [3:0] S_STEP_WAIT = 4'd5;
   localparam logic [3:0] S_DONE      = 4'd11;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  rx_data_i;
   logic        rx_done_i;
   logic        tx_done_i;
   logic        tx_start_o;
   logic [7:0]  tx_data_o;
   logic        halt_signal_i;
   logic [31:0] data_pc_debug_i;
   logic [31:0] data_registers_debug_i = '0;
   logic [31:0] data_mem_debug_i = '0;
   logic        select_debug_or_wireA_o;
   logic [4:0]  addr_reg_debug_o;
   logic        select_debug_or_alu_result_o;
   logic [6:0]  addr_mem_debug_o;
   logic [31:0] data_inst_to_write_o;
   logic        ready_instr_to_write_o;
   logic [31:0] o_dir_mem_write_o;
   logic        en_pipeline_o;
   logic        en_read_inst_o;
   logic [3:0]  state_o;

   int checks = 0, passed = 0;
   int tx_cnt = 0, en_cnt = 0, strobe_cnt = 0;
   int stab_err = 0, slow_idx = -1;
   logic [7:0]  sbq[$];
   logic [63:0] wq[$];
   logic [7:0]  cap [0:259];
   logic [31:0] reg_model [32];
   logic [31:0] mem_model [32];
   logic [7:0]  rb, re;
   int          rd;

   debug_controller dut (
      .clock                        (clock),
      .reset                        (reset),
      .rx_data_i                    (rx_data_i),
      .rx_done_i                    (rx_done_i),
      .tx_done_i                    (tx_done_i),
      .tx_start_o                   (tx_start_o),
      .tx_data_o                    (tx_data_o),
      .halt_signal_i                (halt_signal_i),
      .data_pc_debug_i              (data_pc_debug_i),
      .data_registers_debug_i       (data_registers_debug_i),
      .data_mem_debug_i             (data_mem_debug_i),
      .select_debug_or_wireA_o      (select_debug_or_wireA_o),
      .addr_reg_debug_o             (addr_reg_debug_o),
      .select_debug_or_alu_result_o (select_debug_or_alu_result_o),
      .addr_mem_debug_o             (addr_mem_debug_o),
      .data_inst_to_write_o         (data_inst_to_write_o),
      .ready_instr_to_write_o       (ready_instr_to_write_o),
      .o_dir_mem_write_o            (o_dir_mem_write_o),
      .en_pipeline_o                (en_pipeline_o),
      .en_read_inst_o               (en_read_inst_o),
      .state_o                      (state_o)
   );

   always #5 clock = ~clock;

   // Synchronous-read register file and data memory models.
   always @(posedge clock) begin
      data_registers_debug_i <= reg_model[addr_reg_debug_o];
      data_mem_debug_i       <= mem_model[addr_mem_debug_o[4:0]];
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data_i = b;
      rx_done_i = 1'b1;
      @(negedge clock);
      rx_done_i = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget,
                             input string tag);
      int n = 0;
      while (state_o !== s && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, 64'(state_o), 64'(s));
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) sbq.push_back(w[k*8 +: 8]);
   endtask

   task automatic push_dump(input logic [31:0] pc);
      data_pc_debug_i = pc;
      push_word(pc);
      for (int i = 0; i < 32; i++) push_word(reg_model[i]);
      for (int i = 0; i < 32; i++) push_word(mem_model[i]);
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic load_halt_only();
      wq.push_back({32'hFFFF_FFFF, 32'd0});
      send_byte(8'h4C);
      repeat (4) send_byte(8'hFF);
      repeat (2) @(negedge clock);
      check("reload_ready", 64'(state_o), 64'(S_READY));
   endtask

   always @(negedge clock) begin
      if (en_pipeline_o) en_cnt++;
      if (ready_instr_to_write_o) begin
         strobe_cnt++;
         if (wq.size() == 0) check("wr_extra", 64'd1, 64'd0);
         else check("wr", {data_inst_to_write_o, o_dir_mem_write_o},
                    wq.pop_front());
      end
   end

   // UART transmitter model: answers each start after a delay.
   initial begin
      tx_done_i = 1'b0;
      forever begin
         @(negedge clock);
         tx_done_i = 1'b0;
         if (tx_start_o) begin
            rb = tx_data_o;
            if (tx_cnt < 260) cap[tx_cnt] = rb;
            if (sbq.size() == 0) check("tx_extra", 64'd1, 64'd0);
            else begin
               re = sbq.pop_front();
               check("tx_byte", 64'(rb), 64'(re));
            end
            check("tx_sel", 64'({select_debug_or_wireA_o,
                                 select_debug_or_alu_result_o}), 64'd3);
            rd = (tx_cnt == slow_idx) ? 100 : 2;
            tx_cnt++;
            repeat (rd) begin
               @(negedge clock);
               if (tx_start_o || tx_data_o !== rb) stab_err++;
            end
            tx_done_i = 1'b1;
         end
      end
   end

   initial begin
      reset = 1'b1;
      rx_data_i = '0;
      rx_done_i = 1'b0;
      halt_signal_i = 1'b0;
      data_pc_debug_i = '0;
      for (int i = 0; i < 32; i++) begin
         reg_model[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
         mem_model[i] = 32'hA5A5_0000 + 32'(i) * 32'd7;
      end
      reg_model[5] = 32'hDEAD_BEEF;
      repeat (2) @(negedge clock);

      check("rst_state", 64'(state_o), 64'(S_IDLE));
      check("rst_tx", 64'({tx_start_o, tx_data_o}), 64'd0);
      check("rst_load", 64'({ready_instr_to_write_o,
                             data_inst_to_write_o}), 64'd0);
      check("rst_dir", 64'(o_dir_mem_write_o), 64'd0);
      check("rst_en", 64'({en_pipeline_o, en_read_inst_o,
                           select_debug_or_wireA_o,
                           select_debug_or_alu_result_o}), 64'd0);
      check("rst_addr", 64'({addr_reg_debug_o, addr_mem_debug_o}), 64'd0);
      reset = 1'b0;

      send_byte(8'h4C);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midload_state", 64'(state_o), 64'(S_IDLE));
      check("midload_outs", 64'({ready_instr_to_write_o, en_read_inst_o,
                                 en_pipeline_o, tx_start_o}), 64'd0);
      reset = 1'b0;

      wq.push_back({32'h2001_0005, 32'd0});
      send_byte(8'h4C);
      send_byte(8'h20);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h05);
      repeat (2) @(negedge clock);
      check("wr0_done", 64'(wq.size()), 64'd0);
      check("strobe_one", 64'(strobe_cnt), 64'd1);
      wq.push_back({32'hFFFF_FFFF, 32'd4});
      repeat (4) send_byte(8'hFF);
      repeat (2) @(negedge clock);
      check("wr1_done", 64'(wq.size()), 64'd0);
      check("strobe_two", 64'(strobe_cnt), 64'd2);
      check("load_ready", 64'(state_o), 64'(S_READY));
      check("ready_rd_en", 64'(en_read_inst_o), 64'd1);

      push_dump(32'h0000_0004);
      tx_cnt = 0;
      en_cnt = 0;
      send_byte(8'h43);
      repeat (9) @(negedge clock);
      halt_signal_i = 1'b1;
      @(negedge clock);
      halt_signal_i = 1'b0;
      wait_state(S_DONE, 3000, "run_done");
      check("run_en_cycles", 64'(en_cnt), 64'd10);
      check("run_tx_count", 64'(tx_cnt), 64'd260);
      check("run_sb_empty", 64'(sbq.size()), 64'd0);
      check("done_outs", 64'({en_pipeline_o, en_read_inst_o,
                              select_debug_or_wireA_o}), 64'd0);
      check("reg5_bytes", 64'({cap[24], cap[25], cap[26], cap[27]}),
            64'h0000_0000_DEAD_BEEF);
      check("mem0_bytes", 64'({cap[132], cap[133], cap[134], cap[135]}),
            64'(mem_model[0]));
      send_byte(8'h4C);
      check("done_sticky", 64'(state_o), 64'(S_DONE));

      pulse_reset();
      load_halt_only();
      send_byte(8'h53);
      check("step_wait", 64'(state_o), 64'(S_STEP_WAIT));
      push_dump(32'h0000_0008);
      tx_cnt = 0;
      en_cnt = 0;
      stab_err = 0;
      slow_idx = 5;
      send_byte(8'h4E);
      wait_state(S_STEP_WAIT, 3000, "step_back");
      slow_idx = -1;
      check("step_en_cycles", 64'(en_cnt), 64'd1);
      check("step_tx_count", 64'(tx_cnt), 64'd260);
      check("step_sb_empty", 64'(sbq.size()), 64'd0);
      check("slow_stable", 64'(stab_err), 64'd0);
      send_byte(8'h58);
      repeat (2) @(negedge clock);
      check("x_ignored", 64'(state_o), 64'(S_STEP_WAIT));
      check("x_no_en", 64'(en_cnt), 64'd1);
      send_byte(8'h45);
      check("e_run", 64'(state_o), 64'(S_RUN));
      push_dump(32'h0000_000C);
      tx_cnt = 0;
      halt_signal_i = 1'b1;
      @(negedge clock);
      halt_signal_i = 1'b0;
      wait_state(S_DONE, 3000, "e_done");
      check("e_sb_empty", 64'(sbq.size()), 64'd0);

      pulse_reset();
      load_halt_only();
      send_byte(8'h53);
      push_dump(32'h0000_0010);
      tx_cnt = 0;
      en_cnt = 0;
      send_byte(8'h4E);
      halt_signal_i = 1'b1;
      @(negedge clock);
      halt_signal_i = 1'b0;
      wait_state(S_DONE, 3000, "step_halt_done");
      check("step_halt_en", 64'(en_cnt), 64'd1);
      check("step_halt_tx", 64'(tx_cnt), 64'd260);
      check("strobe_total", 64'(strobe_cnt), 64'd4);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
